load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and the word-only data memory. Accepts byte/half/word
//  load/store requests with byte addresses and issues word-indexed accesses to the data
//  memory. Sub-word stores use read-modify-write. Load data is aligned and sign/zero
//  extended before it is returned to the core as a one-cycle response.
// PARAMETERS
//  IDX_W  3  data-memory word-index width; mem_*_address[IDX_W-1:0] = req_addr[IDX_W+1:2], upper bits 0
// PORTS
//  clk            in   1   single clock, all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  req_valid      in   1   request present
//  req_ready      out  1   1 only in IDLE; request accepted on req_valid&&req_ready
//  req_write      in   1   1=store, 0=load
//  req_size       in   2   00=byte 01=half 10=word 11=illegal
//  req_signed     in   1   loads: 1=sign-extend, 0=zero-extend
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-justified
//  resp_valid     out  1   one-cycle pulse: request complete
//  resp_rdata     out  32  load result; 0 for stores and errors
//  resp_err       out  1   misaligned or illegal size; qualified by resp_valid
//  mem_write      out  1   to data memory write enable
//  mem_read       out  1   to data memory read enable
//  mem_write_address out 32 word index
//  mem_read_address  out 32 word index
//  mem_write_data out  32  merged word
//  mem_read_data  in   32  combinational read data from memory (0 when mem_read=0)
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_write=0,
//    mem_read=0, addresses=0, mem_write_data=0. Reset mid-operation aborts the access:
//    no memory write in the cycle after reset, and no response.
//  - On accept, latch write/size/signed/addr/wdata; later req_* changes are ignored.
//  - FSM states: IDLE, LD, RMW_RD, WR, RSP.
//    IDLE: if accept and error -> RSP with err=1. Else if load -> LD. Else if store word -> WR.
//          Else store byte/half -> RMW_RD.
//    LD: mem_read=1, read addr=idx; capture extracted data -> RSP.
//    RMW_RD: mem_read=1; capture mem_read_data into merge reg -> WR.
//    WR: mem_write=1, write addr=idx, data=merged word (word store: wdata) -> RSP.
//    RSP: resp_valid=1 for exactly one cycle -> IDLE.
//  - Error conditions: size=11; half with addr[0]=1; word with addr[1:0]!=0.
//    No memory access for errors; resp_rdata=0.
//  - Latency in cycles from accept to resp_valid: load 2, word store 2, sub-word store 3,
//    error 1. Max one request in flight; next accept no earlier than the cycle after RSP.
//  - Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1]
//    (lower half if 0, upper half if 1).
//  - Load extract: byte = word[8*lane+:8], half = word[16*addr[1]+:16].
//    Extend per req_signed. Word loads return the full word.
//  - Merge: replace only the addressed lane with the low bits of wdata; other bytes
//    keep the values read in RMW_RD.
//  - mem_read and mem_write are never asserted in the same cycle. Both addresses are
//    held at 0 when their enable is low.
// TESTING
//  1. Reset, then word store 0xDEADBEEF @0x8 -> mem_write 1 cycle, idx=2;
//     resp_valid 2 cycles after accept, err=0.
//  2. Memory idx2=0xDEADBEEF: load byte signed @0x9 -> 0xFFFFFFBE.
//     Unsigned @0xB -> 0x000000DE. Signed half @0xA -> 0xFFFFDEAD.
//  3. Store byte 0x11 @0x9 over 0xDEADBEEF -> RMW read, then write 0xDEAD11EF;
//     resp 3 cycles after accept.
//  4. Word load @0x6, half @0x3, size=11 -> resp_err=1 one cycle after accept;
//     no mem_read or mem_write.
//  5. Assert reset during WR of a byte store -> no mem_write, no resp_valid;
//     req_ready=1 the cycle after reset.
//  6. Back-to-back requests held valid -> req_ready low while busy;
//     second request accepted the cycle after the first RSP; no request lost or duplicated.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles the core request/response handshake and the data-memory port of the load/store unit.
// The LSU connects through the slave modport; the core and memory side use the master modport.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_write_address;
  logic [31:0] mem_read_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_write, mem_read, mem_write_address, mem_read_address, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_write, mem_read, mem_write_address, mem_read_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-only data memory.
// Sub-word stores read-modify-write; loads are lane-aligned and sign/zero extended.
module load_store_unit #(
  parameter int IDX_W = 3
) (
  input logic            clk,
  input logic            reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, RSP} state_t;

  state_t           state;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [1:0]       lane_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      wdata_q;

  logic        err_in;
  logic [31:0] idx_in;
  logic [31:0] idx_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;
  logic        unused_addr;

  assign unused_addr = ^bus.req_addr[31:IDX_W+2];

  always_comb begin
    err_in = (bus.req_size == 2'b11) ||
             (bus.req_size == 2'b01 && bus.req_addr[0]) ||
             (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    idx_in   = {{(32-IDX_W){1'b0}}, bus.req_addr[IDX_W+1:2]};
    idx_word = {{(32-IDX_W){1'b0}}, idx_q};
  end

  // Lane extraction for loads and lane replacement for RMW stores, both from the live read data
  always_comb begin
    ld_byte = bus.mem_read_data[{lane_q, 3'b000} +: 8];
    ld_half = bus.mem_read_data[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = bus.mem_read_data;
    endcase
    merged = bus.mem_read_data;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      size_q                <= 2'b00;
      signed_q              <= 1'b0;
      lane_q                <= 2'b00;
      idx_q                 <= '0;
      wdata_q               <= 16'h0;
      bus.req_ready         <= 1'b1;
      bus.resp_valid        <= 1'b0;
      bus.resp_rdata        <= 32'h0;
      bus.resp_err          <= 1'b0;
      bus.mem_write         <= 1'b0;
      bus.mem_read          <= 1'b0;
      bus.mem_write_address <= 32'h0;
      bus.mem_read_address  <= 32'h0;
      bus.mem_write_data    <= 32'h0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            size_q        <= bus.req_size;
            signed_q      <= bus.req_signed;
            lane_q        <= bus.req_addr[1:0];
            idx_q         <= bus.req_addr[IDX_W+1:2];
            wdata_q       <= bus.req_wdata[15:0];
            bus.req_ready <= 1'b0;
            if (err_in) begin
              state          <= RSP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'h0;
            end else if (!bus.req_write) begin
              state                <= LD;
              bus.mem_read         <= 1'b1;
              bus.mem_read_address <= idx_in;
            end else if (bus.req_size == 2'b10) begin
              state                 <= WR;
              bus.mem_write         <= 1'b1;
              bus.mem_write_address <= idx_in;
              bus.mem_write_data    <= bus.req_wdata;
            end else begin
              state                <= RMW_RD;
              bus.mem_read         <= 1'b1;
              bus.mem_read_address <= idx_in;
            end
          end
        end
        LD: begin
          state                <= RSP;
          bus.mem_read         <= 1'b0;
          bus.mem_read_address <= 32'h0;
          bus.resp_valid       <= 1'b1;
          bus.resp_err         <= 1'b0;
          bus.resp_rdata       <= ld_ext;
        end
        RMW_RD: begin
          state                 <= WR;
          bus.mem_read          <= 1'b0;
          bus.mem_read_address  <= 32'h0;
          bus.mem_write         <= 1'b1;
          bus.mem_write_address <= idx_word;
          bus.mem_write_data    <= merged;
        end
        WR: begin
          state                 <= RSP;
          bus.mem_write         <= 1'b0;
          bus.mem_write_address <= 32'h0;
          bus.mem_write_data    <= 32'h0;
          bus.resp_valid        <= 1'b1;
          bus.resp_err          <= 1'b0;
          bus.resp_rdata        <= 32'h0;
        end
        RSP: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'h0;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec scenarios plus random traffic
// against a byte-addressed reference memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:7] = '{default: 32'h0};
  logic [7:0]  ref_bytes [0:31] = '{default: 8'h0};
  logic [31:0] last_rdata;

  load_store_unit_if bus();

  load_store_unit #(.IDX_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT; an access aborted by reset never lands
  assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_read_address[2:0]] : 32'h0;
  always @(posedge clk) begin
    if (bus.mem_write && !reset) mem[bus.mem_write_address[2:0]] <= bus.mem_write_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int n;
    int base;
    logic [31:0] v;
    n = 1 << sz;
    base = int'(a[4:0]);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic refStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    int base;
    n = 1 << sz;
    base = int'(a[4:0]);
    for (int i = 0; i < n; i++) ref_bytes[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  function automatic logic [31:0] refWord(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // One complete request: handshake, latency, memory traffic and response against the model
  task automatic applyStimulus(input string tag, input logic w, input logic [1:0] sz,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd);
    int n, lat, nr, nw, waitc, exp_lat, exp_r, exp_w;
    logic is_err, got, clash;
    logic [31:0] exp_data, r_addr, w_addr, w_data, obs_err, obs_rdata;
    n = 1 << sz;
    is_err = (sz == 2'b11) || ((a % n) != 0);
    exp_data = (!is_err && !w) ? refLoad(sz, sg, a) : 32'h0;
    exp_lat = is_err ? 1 : ((w && sz != 2'b10) ? 3 : 2);
    exp_r = (!is_err && (!w || sz != 2'b10)) ? 1 : 0;
    exp_w = (!is_err && w) ? 1 : 0;

    bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin step(); waitc++; end
    checkOutput({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom); bus.req_size = 2'($urandom); bus.req_signed = 1'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;

    lat = 0; nr = 0; nw = 0; got = 1'b0; clash = 1'b0;
    r_addr = 32'h0; w_addr = 32'h0; w_data = 32'h0; obs_err = 32'h0; obs_rdata = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.mem_read) begin nr++; r_addr = bus.mem_read_address; end
      if (bus.mem_write) begin nw++; w_addr = bus.mem_write_address; w_data = bus.mem_write_data; end
      if (bus.mem_read && bus.mem_write) clash = 1'b1;
      if (!bus.mem_read && bus.mem_read_address != 32'h0) clash = 1'b1;
      if (!bus.mem_write && bus.mem_write_address != 32'h0) clash = 1'b1;
      if (bus.resp_valid) begin
        got = 1'b1; lat = c;
        obs_err = 32'(bus.resp_err); obs_rdata = bus.resp_rdata;
        break;
      end
      step();
    end
    last_rdata = obs_rdata;
    checkOutput({tag, "/resp_seen"}, 32'(got), 32'd1);
    checkOutput({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "/err"}, obs_err, 32'(is_err));
    checkOutput({tag, "/rdata"}, obs_rdata, exp_data);
    checkOutput({tag, "/reads"}, 32'(nr), 32'(exp_r));
    checkOutput({tag, "/writes"}, 32'(nw), 32'(exp_w));
    checkOutput({tag, "/bus_rules"}, 32'(clash), 32'd0);
    if (exp_r == 1) checkOutput({tag, "/rd_idx"}, r_addr, 32'(a[4:2]));
    if (exp_w == 1) checkOutput({tag, "/wr_idx"}, w_addr, 32'(a[4:2]));
    step();
    checkOutput({tag, "/pulse_end"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, "/ready_back"}, 32'(bus.req_ready), 32'd1);
    if (w && !is_err) refStore(sz, a, wd);
    if (exp_w == 1) begin
      checkOutput({tag, "/wr_data"}, w_data, refWord(int'(a[4:2])));
      checkOutput({tag, "/mem_word"}, mem[a[4:2]], refWord(int'(a[4:2])));
    end
  endtask

  initial begin
    int n_resp, busy, accept_c, resp1_c, resp2_c, resp_seen;
    logic b_pending;
    logic [31:0] rdata_b;
    logic [1:0] sz;
    logic [31:0] a;
    int r;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    step(); step();
    checkOutput("reset/req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset/resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset/resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("reset/resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset/mem_enables", {30'h0, bus.mem_write, bus.mem_read}, 32'h0);
    checkOutput("reset/mem_wr_addr", bus.mem_write_address, 32'h0);
    checkOutput("reset/mem_rd_addr", bus.mem_read_address, 32'h0);
    checkOutput("reset/mem_wr_data", bus.mem_write_data, 32'h0);
    reset = 1'b0;
    step();

    applyStimulus("sw_8", 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
    checkOutput("sw_8/mem2", mem[2], 32'hDEAD_BEEF);
    applyStimulus("lb_9", 1'b0, 2'b00, 1'b1, 32'h0000_0009, 32'h0);
    checkOutput("lb_9/spec", last_rdata, 32'hFFFF_FFBE);
    applyStimulus("lbu_B", 1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0);
    checkOutput("lbu_B/spec", last_rdata, 32'h0000_00DE);
    applyStimulus("lh_A", 1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0);
    checkOutput("lh_A/spec", last_rdata, 32'hFFFF_DEAD);
    applyStimulus("sb_9", 1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'hCAFE_0011);
    checkOutput("sb_9/spec", mem[2], 32'hDEAD_11EF);
    applyStimulus("lw_6", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    applyStimulus("lh_3", 1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'h0);
    applyStimulus("size3", 1'b1, 2'b11, 1'b0, 32'h0000_0004, 32'h1234_5678);

    // Reset while the merged byte store sits in WR
    bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0000_0011; bus.req_wdata = 32'h0000_0077; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    checkOutput("rst_wr/in_wr", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst_wr/no_write", 32'(bus.mem_write), 32'd0);
    checkOutput("rst_wr/ready", 32'(bus.req_ready), 32'd1);
    resp_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.resp_valid) resp_seen++;
      step();
    end
    checkOutput("rst_wr/no_resp", 32'(resp_seen), 32'd0);
    checkOutput("rst_wr/mem4", mem[4], refWord(4));

    // Back-to-back: word store then load of the same word, valid held throughout
    bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0000_0014; bus.req_wdata = 32'h1357_9BDF; bus.req_valid = 1'b1;
    step();
    bus.req_write = 1'b0; bus.req_signed = 1'b1;
    b_pending = 1'b1;
    n_resp = 0; busy = 0; accept_c = 0; resp1_c = 0; resp2_c = 0; rdata_b = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.resp_valid) begin
        n_resp++;
        if (n_resp == 1) resp1_c = c;
        if (n_resp == 2) begin resp2_c = c; rdata_b = bus.resp_rdata; end
      end
      if (b_pending && !bus.req_ready) busy++;
      if (b_pending && bus.req_ready) accept_c = c;
      step();
      if (accept_c != 0 && b_pending) begin b_pending = 1'b0; bus.req_valid = 1'b0; end
    end
    bus.req_valid = 1'b0;
    refStore(2'b10, 32'h0000_0014, 32'h1357_9BDF);
    checkOutput("b2b/busy_cycles", 32'(busy), 32'd2);
    checkOutput("b2b/first_resp", 32'(resp1_c), 32'd2);
    checkOutput("b2b/accept_b", 32'(accept_c), 32'd3);
    checkOutput("b2b/second_resp", 32'(resp2_c), 32'd5);
    checkOutput("b2b/resp_count", 32'(n_resp), 32'd2);
    checkOutput("b2b/rdata", rdata_b, 32'h1357_9BDF);
    checkOutput("b2b/mem5", mem[5], refWord(5));

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      sz = (r == 9) ? 2'b11 : 2'(r % 3);
      a = $urandom;
      if ($urandom_range(0, 4) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      applyStimulus($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
